parking_occupancy_counter: RTL and testbench

- Upstream stage of the free-space counter. Tracks how many cars are parked in a 7-space lot from entry and exit gate sensors.
- Drives the entry and exit gate barriers.
- Presents a registered 3-bit `parked` count, which the downstream block turns into the number of empty spaces.

---
 rtl/parking_occupancy_counter.sv | 103 ++++++++++
 tb/tb_parking_occupancy_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/parking_occupancy_counter.sv
// parking_occupancy_counter: gate control and occupancy count for a small car lot.
// Optional macro REJECT_COUNT_EN adds a saturating 8-bit count of refused entries.
module parking_occupancy_counter #(
  parameter int CAPACITY     = 7,
  parameter int GATE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       entry_pass,
  input  logic       exit_req,
  input  logic       exit_pass,
  output logic [2:0] parked,
  output logic       full,
  output logic       lot_empty,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       entry_reject
`ifdef REJECT_COUNT_EN
  , output logic [7:0] reject_count
`endif
);
  localparam logic E_IDLE = 1'b0;
  localparam logic E_OPEN = 1'b1;
  localparam logic X_IDLE = 1'b0;
  localparam logic X_OPEN = 1'b1;
  localparam logic [2:0] CAP = 3'(CAPACITY);
  localparam logic [7:0] TMO = 8'(GATE_TIMEOUT - 1);
  logic [3:0] s1, s2, prev, ev;
  logic       e_state, x_state;
  logic [7:0] e_tmr, x_tmr;
  logic       inc, dec;
  logic [2:0] parked_nx;
  // Bit order: 0 entry_req, 1 entry_pass, 2 exit_req, 3 exit_pass.
  // Two-flop synchronizer followed by a previous-value register for edge detection.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= {exit_pass, exit_req, entry_pass, entry_req};
      s2   <= s1;
      prev <= s2;
    end
  assign ev = s2 & ~prev;
  // Net count change; simultaneous in/out cancels, ends of range are guarded.
  always_comb begin
    inc       = e_state == E_OPEN && ev[1];
    dec       = x_state == X_OPEN && ev[3];
    parked_nx = (inc && !dec && parked != CAP) ? parked + 3'd1 :
                (dec && !inc && parked != 3'd0) ? parked - 3'd1 : parked;
  end
  // Occupancy register with flags derived from the next value so they stay aligned.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      parked    <= '0;
      full      <= 1'b0;
      lot_empty <= 1'b1;
    end else begin
      parked    <= parked_nx;
      full      <= parked_nx == CAP;
      lot_empty <= parked_nx == 3'd0;
    end
  // Entry gate: open on request if space remains, close on pass or timeout.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e_state      <= E_IDLE;
      e_tmr        <= '0;
      entry_reject <= 1'b0;
    end else begin
      entry_reject <= e_state == E_IDLE && ev[0] && parked >= CAP;
      if (e_state == E_IDLE) begin
        e_tmr <= '0;
        if (ev[0] && parked < CAP) e_state <= E_OPEN;
      end else if (ev[1] || e_tmr == TMO) begin
        e_state <= E_IDLE;
        e_tmr   <= '0;
      end else
        e_tmr <= e_tmr + 8'd1;
    end
  // Exit gate: open on request only when a car is inside, close on pass or timeout.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_state <= X_IDLE;
      x_tmr   <= '0;
    end else if (x_state == X_IDLE) begin
      x_tmr <= '0;
      if (ev[2] && parked != 3'd0) x_state <= X_OPEN;
    end else if (ev[3] || x_tmr == TMO) begin
      x_state <= X_IDLE;
      x_tmr   <= '0;
    end else
      x_tmr <= x_tmr + 8'd1;
  assign entry_gate_open = e_state == E_OPEN;
  assign exit_gate_open  = x_state == X_OPEN;
`ifdef REJECT_COUNT_EN
  // Saturating tally of refused entries.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) reject_count <= '0;
    else if (entry_reject && reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
`endif
endmodule

// File: tb/tb_parking_occupancy_counter.sv
// tb_parking_occupancy_counter: directed checks of gate sequencing and occupancy counting.
module tb_parking_occupancy_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic entry_req = 1'b0, entry_pass = 1'b0, exit_req = 1'b0, exit_pass = 1'b0;
  logic [2:0] parked;
  logic full, lot_empty, entry_gate_open, exit_gate_open, entry_reject;
`ifdef REJECT_COUNT_EN
  logic [7:0] reject_count;
`endif
  int total = 0;
  int passed = 0;
  int cnt_a, cnt_b;
  parking_occupancy_counter dut (
    .clk(clk),
    .rst_n(rst_n),
    .entry_req(entry_req),
    .entry_pass(entry_pass),
    .exit_req(exit_req),
    .exit_pass(exit_pass),
    .parked(parked),
    .full(full),
    .lot_empty(lot_empty),
    .entry_gate_open(entry_gate_open),
    .exit_gate_open(exit_gate_open),
    .entry_reject(entry_reject)
`ifdef REJECT_COUNT_EN
    , .reject_count(reject_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic enter();
    entry_req = 1'b1;
    cyc(3);
    entry_req = 1'b0;
    entry_pass = 1'b1;
    cyc(3);
    entry_pass = 1'b0;
    cyc(1);
  endtask
  task automatic leave();
    exit_req = 1'b1;
    cyc(3);
    exit_req = 1'b0;
    exit_pass = 1'b1;
    cyc(3);
    exit_pass = 1'b0;
    cyc(1);
  endtask
  initial begin
    cyc(3);
    chk("rst_parked", parked, 0);
    chk("rst_empty", lot_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_egate", entry_gate_open, 0);
    chk("rst_xgate", exit_gate_open, 0);
    chk("rst_reject", entry_reject, 0);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_parked", parked, 0);
    chk("post_rst_empty", lot_empty, 1);
    entry_req = 1'b1;
    cyc(2);
    chk("entry_gate_lat2", entry_gate_open, 0);
    cyc(1);
    chk("entry_gate_lat3", entry_gate_open, 1);
    entry_req = 1'b0;
    entry_pass = 1'b1;
    cyc(2);
    chk("pass_lat2_parked", parked, 0);
    chk("pass_lat2_gate", entry_gate_open, 1);
    cyc(1);
    chk("pass_lat3_parked", parked, 1);
    chk("pass_lat3_gate", entry_gate_open, 0);
    chk("pass_lat3_empty", lot_empty, 0);
    entry_pass = 1'b0;
    cyc(2);
    repeat (6) enter();
    chk("fill_parked", parked, 7);
    chk("fill_full", full, 1);
    entry_req = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      cnt_a += int'(entry_gate_open);
      cnt_b += int'(entry_reject);
    end
    entry_req = 1'b0;
    chk("full_gate_cycles", cnt_a, 0);
    chk("full_reject_pulses", cnt_b, 1);
    chk("full_parked_hold", parked, 7);
`ifdef REJECT_COUNT_EN
    chk("reject_count", reject_count, 1);
`endif
    cyc(2);
    leave();
    chk("leave_parked", parked, 6);
    chk("leave_full", full, 0);
    entry_req = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      cnt_a += int'(entry_gate_open);
      if (i == 3) entry_req = 1'b0;
    end
    chk("timeout_open_cycles", cnt_a, 16);
    chk("timeout_gate", entry_gate_open, 0);
    chk("timeout_parked", parked, 6);
    repeat (3) leave();
    chk("pre_sim_parked", parked, 3);
    entry_req = 1'b1;
    exit_req = 1'b1;
    cyc(3);
    chk("sim_egate_open", entry_gate_open, 1);
    chk("sim_xgate_open", exit_gate_open, 1);
    entry_req = 1'b0;
    exit_req = 1'b0;
    entry_pass = 1'b1;
    exit_pass = 1'b1;
    cyc(2);
    chk("sim_lat2_egate", entry_gate_open, 1);
    chk("sim_lat2_xgate", exit_gate_open, 1);
    cyc(1);
    chk("sim_parked", parked, 3);
    chk("sim_egate_closed", entry_gate_open, 0);
    chk("sim_xgate_closed", exit_gate_open, 0);
    entry_pass = 1'b0;
    exit_pass = 1'b0;
    cyc(2);
    repeat (3) leave();
    chk("drain_parked", parked, 0);
    chk("drain_empty", lot_empty, 1);
    exit_req = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      cnt_a += int'(exit_gate_open);
    end
    exit_req = 1'b0;
    chk("empty_exit_gate", cnt_a, 0);
    chk("empty_exit_parked", parked, 0);
    cyc(2);
    repeat (2) enter();
    chk("pre_rst_parked", parked, 2);
    exit_req = 1'b1;
    cyc(3);
    chk("pre_rst_xgate", exit_gate_open, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_xgate", exit_gate_open, 0);
    chk("midrst_parked", parked, 0);
    chk("midrst_empty", lot_empty, 1);
    cyc(2);
    rst_n = 1'b1;
    exit_req = 1'b0;
    cyc(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
